sd_spi_responder: RTL and testbench
===================================

Name: sd_spi_responder

Overview:
- Block-storage responder for the sdspihost command/byte handshake: spi_rst, r_block/r_byte, w_block/w_byte, busy, err and crc_err.
- Services requests from an on-chip memory window of 512-byte blocks, so an autotest controller can run in simulation or on FPGA without an SD card.
- Includes a backdoor port so a bench or a debug host can preload blocks and read back results.

Parameters:
- BLOCKS_LOG2, 4: number of emulated blocks is 2^BLOCKS_LOG2.
- BASE_BLOCK, 32'h100000: block address mapped to internal block 0.
- INIT_CYCLES, 16: busy length of an init (spi_rst) operation; minimum 1.
- BLOCK_LATENCY, 8: busy length of block open and of write commit; minimum 1.
- BYTE_CYCLES, 2: busy length per byte transfer; minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- spi_rst  in  1  init request, level.
- spi_r_block  in  1  read-block session, held for the whole block.
- spi_r_byte  in  1  advance to the next read byte.
- spi_r_multi_block  in  1  unsupported; raises error.
- spi_w_block  in  1  write-block session, held for the whole block.
- spi_w_byte  in  1  write one byte.
- spi_block_addr  in  32  block address, sampled at block open.
- spi_data_in  in  8  write data.
- spi_data_out  out  8  read data, registered.
- spi_busy  out  1  operation in progress, registered.
- spi_err  out  1  sticky address/command error.
- spi_crc_err  out  1  write integrity error.
- mem_addr  in  BLOCKS_LOG2+9  backdoor byte address.
- mem_we  in  1  backdoor write enable.
- mem_din  in  8  backdoor write data.
- mem_dout  out  8  backdoor read data, 1-cycle latency.

Behaviour:
- Reset: state UNINIT; spi_busy=0, spi_err=0, spi_crc_err=0, spi_data_out=8'hFF, mem_dout=0, byte pointer=0. Memory contents are not cleared.
- spi_busy rises on the clock edge after a request is sampled. The initiator may therefore test busy one cycle after asserting a request.
- Priority: spi_rst overrides every state, including mid-read, mid-write and ERR. It clears spi_err, spi_crc_err and the pointer and enters INIT.
- UNINIT: all requests except spi_rst are ignored; busy stays 0.
- INIT:
  - busy=1 while an internal counter runs INIT_CYCLES.
  - Exit to READY (busy=0) only when the count is done AND spi_rst=0.
- READY:
  - r_multi_block=1 -> ERR.
  - r_block and w_block both 1 -> ERR.
  - r_block=1 -> RD_LOAD.
  - w_block=1 -> WR_PREP.
  - Either block open latches spi_block_addr. Offset = addr - BASE_BLOCK (32-bit unsigned). Offset >= 2^BLOCKS_LOG2 -> ERR after 1 busy cycle.
- RD_LOAD:
  - busy=1 for BLOCK_LATENCY cycles.
  - On exit: spi_data_out = byte 0, pointer = 1, state RD_OPEN with busy=0.
  - Byte 0 is therefore valid before any r_byte.
- RD_OPEN:
  - r_byte=1 -> RD_BYTE. Busy for BYTE_CYCLES; on entry spi_data_out = byte[pointer], pointer++.
  - Pointer >= 512 returns 8'hFF. Pointer saturates at 514.
  - r_block=0 while not busy -> READY; spi_data_out holds its last value.
  - If r_byte is still high when busy drops, that is a new request.
- WR_PREP: busy for BLOCK_LATENCY cycles, then WR_OPEN with busy=0 and pointer=0.
- WR_OPEN:
  - w_byte=1 -> WR_BYTE, busy for BYTE_CYCLES.
  - spi_data_in is captured on the last busy cycle, not the request cycle, because the initiator's data register updates one cycle after it asserts w_byte.
  - Pointer < 512: the byte is written to memory. Otherwise it is discarded as a trailer. Pointer++, saturating at 1023.
- w_block=0 in WR_OPEN -> WR_COMMIT:
  - busy for BLOCK_LATENCY cycles, then READY.
  - If fewer than 512 bytes were received, spi_crc_err=1 until the next block open or spi_rst.
- ERR: busy=0, spi_err=1; left only via spi_rst.
- Backdoor port:
  - Memory is dual-port; the backdoor is always active.
  - Same-address same-cycle write collision: the responder write wins and the backdoor write is dropped.
- Address arithmetic:
  - Memory byte address = {offset[BLOCKS_LOG2-1:0], pointer[8:0]}.
  - Offset and pointer never wrap into the neighbouring block.

Optional Feature:
SD_RESP_CRC16_EN
- Defined:
  - CRC16-CCITT (poly 0x1021, init 0) runs over the 512 data bytes of each block.
  - Reads: bytes 512 and 513 return CRC[15:8] and CRC[7:0].
  - Writes: trailer bytes 512 and 513 are compared with the computed CRC; a mismatch sets spi_crc_err at commit.
- Undefined: trailer reads return 8'hFF, write trailers are ignored, and spi_crc_err flags only short writes.

Test Plan:
- Init: reset, pulse spi_rst for 2 cycles -> busy=1 from the next edge for 16 cycles, then busy=0 and spi_err=0. r_block before the init -> busy stays 0.
- Read: preload block 0x100000 with AA BB CC DD 03 and i&0xFF elsewhere; open read, issue 512 r_byte -> byte0=AA before the first r_byte, then BB CC DD 03 ..., final byte 0xFF (CRC off).
- Write: write 516 bytes (value = index&0xFF) to 0x100001 with data_in updating one cycle after w_byte, drop w_block -> backdoor readback of addr 512..1023 equals 00..FF repeating; spi_crc_err=0.
- Short write of 100 bytes -> spi_crc_err=1; next block open -> spi_crc_err cleared.
- Block address 0x0FFFFF or 0x100010 -> spi_err=1, busy=0, further requests ignored; spi_rst -> init sequence and spi_err=0.
- spi_rst mid-read (byte 37) -> busy=1 for INIT_CYCLES; a subsequent read of the same block starts again at byte0=AA.

Source files
------------

// File: rtl/sd_spi_responder.sv
// sd_spi_responder
// Block-storage responder for the sdspihost command/byte handshake. Requests
// are served from an on-chip memory of 2^BLOCKS_LOG2 blocks of 512 bytes, and a
// backdoor port lets a host preload blocks and read back results.
//
// Optional feature macro: SD_RESP_CRC16_EN
//   defined   : CRC16-CCITT (poly 0x1021, init 0) over the 512 data bytes.
//               Read trailer bytes 512/513 return CRC[15:8]/CRC[7:0]. Write
//               trailer bytes 512/513 are compared against the CRC, and a
//               mismatch raises spi_crc_err at commit.
//   undefined : read trailers return 8'hFF, write trailers are ignored, and
//               spi_crc_err flags only short writes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   spi_rst                  init request (level)
//   spi_r_block, spi_r_byte  read session / advance to the next read byte
//   spi_r_multi_block        unsupported command, raises spi_err
//   spi_w_block, spi_w_byte  write session / write one byte
//   spi_block_addr           block address, sampled at block open
//   spi_data_in              write data
//   spi_data_out             registered read data
//   spi_busy                 registered busy
//   spi_err                  sticky address/command error
//   spi_crc_err              write integrity error
//   mem_addr/we/din/dout     backdoor byte port, 1-cycle read latency
//
// State table
//   S_UNINIT    | waiting for the first spi_rst, all other requests ignored
//   S_INIT      | init countdown, holds until spi_rst is released
//   S_READY     | idle, accepts block open
//   S_RD_LOAD   | read block open latency, then byte 0 is presented
//   S_RD_OPEN   | read session idle, waiting for r_byte or session end
//   S_RD_BYTE   | read byte transfer in progress
//   S_WR_PREP   | write block open latency
//   S_WR_OPEN   | write session idle, waiting for w_byte or session end
//   S_WR_BYTE   | write byte transfer, data sampled on the last busy cycle
//   S_WR_COMMIT | write commit latency, short-write check
//   S_ERR       | sticky error, left only via spi_rst

module sd_spi_responder #(
    parameter int          BLOCKS_LOG2   = 4,
    parameter logic [31:0] BASE_BLOCK    = 32'h100000,
    parameter int          INIT_CYCLES   = 16,
    parameter int          BLOCK_LATENCY = 8,
    parameter int          BYTE_CYCLES   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_rst,
    input  logic                   spi_r_block,
    input  logic                   spi_r_byte,
    input  logic                   spi_r_multi_block,
    input  logic                   spi_w_block,
    input  logic                   spi_w_byte,
    input  logic [31:0]            spi_block_addr,
    input  logic [7:0]             spi_data_in,
    output logic [7:0]             spi_data_out,
    output logic                   spi_busy,
    output logic                   spi_err,
    output logic                   spi_crc_err,
    input  logic [BLOCKS_LOG2+8:0] mem_addr,
    input  logic                   mem_we,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout
);

    localparam int AW    = BLOCKS_LOG2 + 9;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        S_UNINIT, S_INIT, S_READY, S_RD_LOAD, S_RD_OPEN, S_RD_BYTE,
        S_WR_PREP, S_WR_OPEN, S_WR_BYTE, S_WR_COMMIT, S_ERR
    } state_t;

    logic [7:0]             mem [DEPTH];
    state_t                 state;
    logic [15:0]            cnt;
    logic [9:0]             ptr;
    logic [BLOCKS_LOG2-1:0] blk;
    logic                   addr_bad;

    logic [31:0]   offset_full;
    logic          open_bad;
    logic          cnt_done;
    logic [AW-1:0] resp_addr;
    logic          resp_we;
    logic [7:0]    rd_byte;
    logic [9:0]    ptr_rd_next;
    logic [9:0]    ptr_wr_next;

`ifdef SD_RESP_CRC16_EN
    logic [15:0] crc;
    logic        crc_bad;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction
`endif

    // Unsigned subtraction: addresses below BASE_BLOCK wrap to huge offsets
    // and are rejected by the same range test.
    assign offset_full = spi_block_addr - BASE_BLOCK;
    assign open_bad    = (offset_full >> BLOCKS_LOG2) != 32'd0;
    assign cnt_done    = (cnt == 16'd0);
    assign resp_addr   = {blk, ptr[8:0]};
    assign ptr_rd_next = (ptr >= 10'd514) ? ptr : ptr + 10'd1;
    assign ptr_wr_next = (ptr == 10'd1023) ? ptr : ptr + 10'd1;

    // Trailer bytes (pointer >= 512) never touch memory, so a session cannot
    // spill into the neighbouring block.
    assign resp_we = (state == S_WR_BYTE) && cnt_done && !ptr[9] && !spi_rst;

    always_comb begin
        rd_byte = 8'hFF;
        if (!ptr[9]) begin
            rd_byte = mem[resp_addr];
        end
`ifdef SD_RESP_CRC16_EN
        else if (ptr == 10'd512) begin
            rd_byte = crc[15:8];
        end else if (ptr == 10'd513) begin
            rd_byte = crc[7:0];
        end
`endif
    end

    // Responder write wins a same-address collision with the backdoor.
    always_ff @(posedge clk) begin
        if (resp_we) begin
            mem[resp_addr] <= spi_data_in;
        end
        if (mem_we && !(resp_we && (resp_addr == mem_addr))) begin
            mem[mem_addr] <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout <= 8'h00;
        end else begin
            mem_dout <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_UNINIT;
            spi_busy     <= 1'b0;
            spi_err      <= 1'b0;
            spi_crc_err  <= 1'b0;
            spi_data_out <= 8'hFF;
            ptr          <= 10'd0;
            cnt          <= 16'd0;
            blk          <= '0;
            addr_bad     <= 1'b0;
`ifdef SD_RESP_CRC16_EN
            crc          <= 16'h0000;
            crc_bad      <= 1'b0;
`endif
        end else if (spi_rst && (state != S_INIT)) begin
            state       <= S_INIT;
            spi_busy    <= 1'b1;
            spi_err     <= 1'b0;
            spi_crc_err <= 1'b0;
            ptr         <= 10'd0;
            cnt         <= 16'(INIT_CYCLES - 1);
        end else begin
            case (state)
                S_UNINIT: begin
                    spi_busy <= 1'b0;
                end
                // Counter keeps running while spi_rst is held; only the
                // exit waits for its release.
                S_INIT: begin
                    spi_err     <= 1'b0;
                    spi_crc_err <= 1'b0;
                    ptr         <= 10'd0;
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else if (!spi_rst) begin
                        state    <= S_READY;
                        spi_busy <= 1'b0;
                    end
                end
                S_READY: begin
                    if (spi_r_multi_block || (spi_r_block && spi_w_block)) begin
                        state   <= S_ERR;
                        spi_err <= 1'b1;
                    end else if (spi_r_block || spi_w_block) begin
                        spi_crc_err <= 1'b0;
                        blk         <= offset_full[BLOCKS_LOG2-1:0];
                        addr_bad    <= open_bad;
                        ptr         <= 10'd0;
                        spi_busy    <= 1'b1;
                        cnt         <= open_bad ? 16'd0 : 16'(BLOCK_LATENCY - 1);
                        state       <= spi_r_block ? S_RD_LOAD : S_WR_PREP;
                    end
                end
                S_RD_LOAD: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        spi_busy <= 1'b0;
                        if (addr_bad) begin
                            state   <= S_ERR;
                            spi_err <= 1'b1;
                        end else begin
                            spi_data_out <= rd_byte;
                            ptr          <= 10'd1;
                            state        <= S_RD_OPEN;
`ifdef SD_RESP_CRC16_EN
                            crc          <= crc16_byte(16'h0000, rd_byte);
`endif
                        end
                    end
                end
                S_RD_OPEN: begin
                    if (!spi_r_block) begin
                        state <= S_READY;
                    end else if (spi_r_byte) begin
                        state        <= S_RD_BYTE;
                        spi_busy     <= 1'b1;
                        cnt          <= 16'(BYTE_CYCLES - 1);
                        spi_data_out <= rd_byte;
                        ptr          <= ptr_rd_next;
`ifdef SD_RESP_CRC16_EN
                        if (!ptr[9]) begin
                            crc <= crc16_byte(crc, rd_byte);
                        end
`endif
                    end
                end
                S_RD_BYTE: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        spi_busy <= 1'b0;
                        state    <= S_RD_OPEN;
                    end
                end
                S_WR_PREP: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        spi_busy <= 1'b0;
                        if (addr_bad) begin
                            state   <= S_ERR;
                            spi_err <= 1'b1;
                        end else begin
                            state <= S_WR_OPEN;
                            ptr   <= 10'd0;
`ifdef SD_RESP_CRC16_EN
                            crc     <= 16'h0000;
                            crc_bad <= 1'b0;
`endif
                        end
                    end
                end
                S_WR_OPEN: begin
                    if (!spi_w_block) begin
                        state    <= S_WR_COMMIT;
                        spi_busy <= 1'b1;
                        cnt      <= 16'(BLOCK_LATENCY - 1);
                    end else if (spi_w_byte) begin
                        state    <= S_WR_BYTE;
                        spi_busy <= 1'b1;
                        cnt      <= 16'(BYTE_CYCLES - 1);
                    end
                end
                // Data is taken on the last busy cycle: the initiator's data
                // register lags its w_byte strobe by one cycle.
                S_WR_BYTE: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        spi_busy <= 1'b0;
                        state    <= S_WR_OPEN;
                        ptr      <= ptr_wr_next;
`ifdef SD_RESP_CRC16_EN
                        if (!ptr[9]) begin
                            crc <= crc16_byte(crc, spi_data_in);
                        end else if ((ptr == 10'd512) && (spi_data_in != crc[15:8])) begin
                            crc_bad <= 1'b1;
                        end else if ((ptr == 10'd513) && (spi_data_in != crc[7:0])) begin
                            crc_bad <= 1'b1;
                        end
`endif
                    end
                end
                S_WR_COMMIT: begin
                    if (!cnt_done) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        spi_busy <= 1'b0;
                        state    <= S_READY;
`ifdef SD_RESP_CRC16_EN
                        spi_crc_err <= !ptr[9] || crc_bad;
`else
                        spi_crc_err <= !ptr[9];
`endif
                    end
                end
                S_ERR: begin
                    spi_busy <= 1'b0;
                    spi_err  <= 1'b1;
                end
                default: begin
                    state    <= S_UNINIT;
                    spi_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Self-checking bench for sd_spi_responder: randomized block contents and
// block choices checked against a byte-array model of the storage.
module tb_sd_spi_responder;

    localparam int          BL2     = 4;
    localparam logic [31:0] BASE    = 32'h100000;
    localparam int          INIT_C  = 16;
    localparam int          BLK_LAT = 8;
    localparam int          BYTE_C  = 2;
    localparam int          NBYTES  = 512 << BL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_rst = 1'b0;
    logic        spi_r_block = 1'b0;
    logic        spi_r_byte = 1'b0;
    logic        spi_r_multi_block = 1'b0;
    logic        spi_w_block = 1'b0;
    logic        spi_w_byte = 1'b0;
    logic [31:0] spi_block_addr = 32'd0;
    logic [7:0]  spi_data_in = 8'd0;
    logic [7:0]  spi_data_out;
    logic        spi_busy;
    logic        spi_err;
    logic        spi_crc_err;
    logic [BL2+8:0] mem_addr = '0;
    logic        mem_we = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;

    logic [7:0] ref_mem [NBYTES];
    logic [7:0] wdata [1024];
    int checks = 0;
    int passed = 0;

    sd_spi_responder #(
        .BLOCKS_LOG2(BL2), .BASE_BLOCK(BASE), .INIT_CYCLES(INIT_C),
        .BLOCK_LATENCY(BLK_LAT), .BYTE_CYCLES(BYTE_C)
    ) dut (
        .clk(clk), .rst(rst), .spi_rst(spi_rst),
        .spi_r_block(spi_r_block), .spi_r_byte(spi_r_byte),
        .spi_r_multi_block(spi_r_multi_block),
        .spi_w_block(spi_w_block), .spi_w_byte(spi_w_byte),
        .spi_block_addr(spi_block_addr), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_err(spi_err),
        .spi_crc_err(spi_crc_err), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive busy observations starting at the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (spi_busy === 1'b1 && n < 5000) begin
            n++;
            step();
        end
    endtask

`ifdef SD_RESP_CRC16_EN
    // Bit-serial CRC16-CCITT over the model's copy of a block.
    function automatic logic [15:0] model_crc(input int blk);
        logic [15:0] c;
        logic fb;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ ref_mem[blk*512 + i][b];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    function automatic logic [7:0] exp_byte(input int blk, input int idx);
        logic [15:0] c;
        c = 16'h0000;
        if (idx < 512) return ref_mem[blk*512 + idx];
`ifdef SD_RESP_CRC16_EN
        c = model_crc(blk);
        if (idx == 512) return c[15:8];
        if (idx == 513) return c[7:0];
`endif
        return 8'hFF + c[7:0] - c[7:0];
    endfunction

    task automatic do_read(input int blk, input int nbytes, input bit close);
        int n;
        logic [7:0] e;
        spi_block_addr = BASE + 32'(blk);
        spi_r_block = 1'b1;
        step();
        checks++;
        if (spi_crc_err !== 1'b0) $display("FAIL rd_open_crc_clear: got %b want 0", spi_crc_err);
        else passed++;
        count_busy(n);
        checks++;
        if (n != BLK_LAT) $display("FAIL rd_load_busy: got %0d cycles want %0d", n, BLK_LAT);
        else passed++;
        e = exp_byte(blk, 0);
        checks++;
        if (spi_data_out !== e) $display("FAIL rd_byte0 blk %0d: got %h want %h", blk, spi_data_out, e);
        else passed++;
        for (int k = 1; k <= nbytes; k++) begin
            spi_r_byte = 1'b1;
            step();
            spi_r_byte = 1'b0;
            e = exp_byte(blk, k);
            checks++;
            if (spi_data_out !== e) $display("FAIL rd_byte blk %0d idx %0d: got %h want %h", blk, k, spi_data_out, e);
            else passed++;
            count_busy(n);
            checks++;
            if (n != BYTE_C) $display("FAIL rd_byte_busy idx %0d: got %0d want %0d", k, n, BYTE_C);
            else passed++;
        end
        if (close) begin
            spi_r_block = 1'b0;
            step();
            e = exp_byte(blk, nbytes);
            checks++;
            if (spi_busy !== 1'b0 || spi_data_out !== e)
                $display("FAIL rd_close: busy %b data %h, want busy 0 data %h", spi_busy, spi_data_out, e);
            else passed++;
        end
    endtask

    task automatic do_write(input int blk, input int nbytes);
        int n;
        logic exp_crc;
        spi_block_addr = BASE + 32'(blk);
        spi_w_block = 1'b1;
        step();
        checks++;
        if (spi_crc_err !== 1'b0) $display("FAIL wr_open_crc_clear: got %b want 0", spi_crc_err);
        else passed++;
        count_busy(n);
        checks++;
        if (n != BLK_LAT) $display("FAIL wr_prep_busy: got %0d want %0d", n, BLK_LAT);
        else passed++;
        for (int k = 0; k < nbytes; k++) begin
            spi_w_byte = 1'b1;
            step();
            spi_w_byte = 1'b0;
            spi_data_in = wdata[k];
            count_busy(n);
            checks++;
            if (n != BYTE_C) $display("FAIL wr_byte_busy idx %0d: got %0d want %0d", k, n, BYTE_C);
            else passed++;
            if (k < 512) ref_mem[blk*512 + k] = wdata[k];
        end
        exp_crc = (nbytes < 512);
`ifdef SD_RESP_CRC16_EN
        if (nbytes > 512 && wdata[512] != model_crc(blk) >> 8) exp_crc = 1'b1;
        if (nbytes > 513 && wdata[513] != model_crc(blk) % 256) exp_crc = 1'b1;
`endif
        spi_w_block = 1'b0;
        step();
        count_busy(n);
        checks++;
        if (n != BLK_LAT) $display("FAIL wr_commit_busy: got %0d want %0d", n, BLK_LAT);
        else passed++;
        checks++;
        if (spi_crc_err !== exp_crc) $display("FAIL wr_crc_err %0d bytes: got %b want %b", nbytes, spi_crc_err, exp_crc);
        else passed++;
    endtask

    task automatic bd_check(input int blk);
        for (int i = 0; i < 512; i++) begin
            mem_addr = (BL2+9)'(blk*512 + i);
            step();
            checks++;
            if (mem_dout !== ref_mem[blk*512 + i])
                $display("FAIL backdoor_rd addr %0d: got %h want %h", blk*512 + i, mem_dout, ref_mem[blk*512 + i]);
            else passed++;
        end
    endtask

    task automatic recover(input string tag);
        int n;
        spi_rst = 1'b1;
        step();
        spi_rst = 1'b0;
        count_busy(n);
        checks++;
        if (n != INIT_C) $display("FAIL %s_init_busy: got %0d want %0d", tag, n, INIT_C);
        else passed++;
        checks++;
        if (spi_err !== 1'b0) $display("FAIL %s_err_clear: got %b want 0", tag, spi_err);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b0 || spi_crc_err !== 1'b0)
            $display("FAIL reset_flags: busy %b err %b crc %b want 000", spi_busy, spi_err, spi_crc_err);
        else passed++;
        checks++;
        if (spi_data_out !== 8'hFF) $display("FAIL reset_data_out: got %h want ff", spi_data_out);
        else passed++;
        checks++;
        if (mem_dout !== 8'h00) $display("FAIL reset_mem_dout: got %h want 00", mem_dout);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_uninit();
        bit seen = 1'b0;
        spi_block_addr = BASE;
        spi_r_block = 1'b1;
        repeat (10) begin
            step();
            if (spi_busy !== 1'b0) seen = 1'b1;
        end
        spi_r_block = 1'b0;
        checks++;
        if (seen) $display("FAIL uninit_ignore: busy seen 1 want 0");
        else passed++;
    endtask

    task automatic test_preload();
        mem_we = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
            ref_mem[i] = (i < 512) ? 8'(i) : 8'($urandom);
            if (i == 0) ref_mem[i] = 8'hAA;
            if (i == 1) ref_mem[i] = 8'hBB;
            if (i == 2) ref_mem[i] = 8'hCC;
            if (i == 3) ref_mem[i] = 8'hDD;
            if (i == 4) ref_mem[i] = 8'h03;
            mem_addr = (BL2+9)'(i);
            mem_din = ref_mem[i];
            step();
        end
        mem_we = 1'b0;
    endtask

    task automatic test_init();
        int n;
        spi_rst = 1'b1;
        step();
        checks++;
        if (spi_busy !== 1'b1) $display("FAIL init_busy_rise: got %b want 1", spi_busy);
        else passed++;
        step();
        spi_rst = 1'b0;
        count_busy(n);
        n++;
        checks++;
        if (n != INIT_C) $display("FAIL init_busy_len: got %0d want %0d", n, INIT_C);
        else passed++;
        checks++;
        if (spi_err !== 1'b0) $display("FAIL init_err: got %b want 0", spi_err);
        else passed++;
    endtask

    task automatic test_write_full();
        for (int k = 0; k < 516; k++) wdata[k] = 8'(k);
        do_write(1, 516);
        bd_check(1);
    endtask

    task automatic test_short_write();
        int blk = $urandom_range(2, 15);
        for (int k = 0; k < 100; k++) wdata[k] = 8'($urandom);
        do_write(blk, 100);
        do_read(blk, 120, 1);
    endtask

    task automatic bad_open(input logic [31:0] a, input bit rd);
        spi_block_addr = a;
        if (rd) spi_r_block = 1'b1;
        else spi_w_block = 1'b1;
        step();
        checks++;
        if (spi_busy !== 1'b1) $display("FAIL bad_addr_busy1 %h: got %b want 1", a, spi_busy);
        else passed++;
        step();
        checks++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b1)
            $display("FAIL bad_addr_err %h: busy %b err %b want busy 0 err 1", a, spi_busy, spi_err);
        else passed++;
        spi_r_block = 1'b0;
        spi_w_block = 1'b0;
        step();
        spi_block_addr = BASE;
        if (rd) spi_w_block = 1'b1;
        else spi_r_block = 1'b1;
        repeat (5) step();
        checks++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b1)
            $display("FAIL err_ignore: busy %b err %b want busy 0 err 1", spi_busy, spi_err);
        else passed++;
        spi_r_block = 1'b0;
        spi_w_block = 1'b0;
        recover("bad_addr");
    endtask

    task automatic test_cmd_errors();
        spi_r_multi_block = 1'b1;
        step();
        spi_r_multi_block = 1'b0;
        checks++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b1)
            $display("FAIL multi_block_err: busy %b err %b want busy 0 err 1", spi_busy, spi_err);
        else passed++;
        recover("multi");
        spi_block_addr = BASE;
        spi_r_block = 1'b1;
        spi_w_block = 1'b1;
        step();
        spi_r_block = 1'b0;
        spi_w_block = 1'b0;
        checks++;
        if (spi_busy !== 1'b0 || spi_err !== 1'b1)
            $display("FAIL rw_both_err: busy %b err %b want busy 0 err 1", spi_busy, spi_err);
        else passed++;
        recover("rw_both");
    endtask

    task automatic test_rst_mid_read();
        int n;
        do_read(0, 37, 1'b0);
        spi_rst = 1'b1;
        spi_r_block = 1'b0;
        step();
        spi_rst = 1'b0;
        count_busy(n);
        checks++;
        if (n != INIT_C) $display("FAIL mid_read_rst_busy: got %0d want %0d", n, INIT_C);
        else passed++;
        do_read(0, 4, 1'b1);
    endtask

    task automatic test_collision();
        int n;
        int blk = $urandom_range(2, 15);
        logic [7:0] d0 = 8'($urandom);
        logic [7:0] d1 = 8'($urandom);
        logic [7:0] d2 = 8'($urandom);
        spi_block_addr = BASE + 32'(blk);
        spi_w_block = 1'b1;
        step();
        count_busy(n);
        for (int k = 0; k < 2; k++) begin
            spi_w_byte = 1'b1;
            step();
            spi_w_byte = 1'b0;
            spi_data_in = (k == 0) ? d0 : d1;
            step();
            mem_we = 1'b1;
            mem_addr = (BL2+9)'((k == 0) ? blk*512 : blk*512 + 300);
            mem_din = (k == 0) ? ~d0 : d2;
            step();
            mem_we = 1'b0;
        end
        ref_mem[blk*512] = d0;
        ref_mem[blk*512 + 1] = d1;
        ref_mem[blk*512 + 300] = d2;
        spi_w_block = 1'b0;
        step();
        count_busy(n);
        checks++;
        if (spi_crc_err !== 1'b1) $display("FAIL collision_short_crc: got %b want 1", spi_crc_err);
        else passed++;
        bd_check(blk);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 3; it++) begin
            int blk = $urandom_range(0, 15);
            for (int k = 0; k < 512; k++) wdata[k] = 8'($urandom);
            do_write(blk, 512);
            do_read(blk, $urandom_range(10, 514), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_uninit();
        test_preload();
        test_init();
        do_read(0, 512, 1'b1);
        test_write_full();
        test_short_write();
        bad_open(32'h000F_FFFF, 1'b1);
        bad_open(32'h0010_0010, 1'b0);
        test_cmd_errors();
        test_rst_mid_read();
        test_collision();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
